// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// write_winner() resolves same-address write collisions for storage and bypass alike.
package regfile_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int AW_DEF   = $clog2(NREG_DEF);
  localparam int MAX_NWR  = 4;

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] xlen_t;

  typedef struct packed {
    logic       hit;
    logic [1:0] port;
  } winner_t;

  // Highest-index matching port wins; later iterations overwrite earlier ones.
  function automatic winner_t write_winner(input logic [MAX_NWR-1:0] match);
    winner_t w;
    w = '0;
    for (int p = 0; p < MAX_NWR; p++) begin
      if (match[p]) begin
        w.hit  = 1'b1;
        w.port = 2'(p);
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Operand read, writeback and issue-claim signals of the register file.
// No valid/ready: every request present on a rising edge is accepted in that cycle.
interface regfile_mp_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int NWR  = 1
);
  localparam int AW = $clog2(NREG);

  logic [NRD-1:0][AW-1:0]   rd_addr_i;
  logic [NRD-1:0][XLEN-1:0] rd_data_o;
  logic [NRD-1:0]           rd_busy_o;
  logic [NWR-1:0]           wr_en_i;
  logic [NWR-1:0][AW-1:0]   wr_addr_i;
  logic [NWR-1:0][XLEN-1:0] wr_data_i;
  logic                     claim_en_i;
  logic [AW-1:0]            claim_addr_i;
  logic                     flush_i;

  modport master (
    output rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, claim_en_i, claim_addr_i, flush_i,
    input  rd_data_o, rd_busy_o
  );

  modport slave (
    input  rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, claim_en_i, claim_addr_i, flush_i,
    output rd_data_o, rd_busy_o
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set by claim, cleared by write, all cleared by flush.
// Reads see same-cycle write clears but not same-cycle claims.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG = 32,
  parameter int NRD  = 2,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [MAX_NWR-1:0]          wr_act,
  input  logic [MAX_NWR-1:0][AW-1:0]  wr_addr,
  input  logic                        claim_act,
  input  logic [AW-1:0]               claim_addr,
  input  logic                        flush,
  input  logic [NRD-1:0][AW-1:0]      rd_addr,
  output logic [NRD-1:0]              rd_busy
);

  logic [NREG-1:0]              busy;
  logic [NREG-1:0]              busy_nxt;
  logic [NRD-1:0][MAX_NWR-1:0]  rd_match;
  winner_t [NRD-1:0]            rd_win;

  // Order matters: claim supersedes a write clear, flush supersedes both.
  always_comb begin
    busy_nxt = busy;
    for (int p = 0; p < MAX_NWR; p++) begin
      if (wr_act[p]) busy_nxt[wr_addr[p]] = 1'b0;
    end
    if (claim_act) busy_nxt[claim_addr] = 1'b1;
    if (flush) busy_nxt = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  always_comb begin
    rd_match = '0;
    rd_win   = '0;
    rd_busy  = '0;
    for (int k = 0; k < NRD; k++) begin
      for (int p = 0; p < MAX_NWR; p++) begin
        rd_match[k][p] = wr_act[p] && (wr_addr[p] == rd_addr[k]);
      end
      rd_win[k]  = write_winner(rd_match[k]);
      rd_busy[k] = rd_win[k].hit ? 1'b0 : busy[rd_addr[k]];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-first bypass and a busy scoreboard.
// Write ports are padded to MAX_NWR internally so collision logic is width-independent.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREG     = NREG_DEF,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREG)
) (
  input logic         clk_i,
  input logic         rst_i,
  regfile_mp_if.slave bus
);

  logic [MAX_NWR-1:0]            wr_act;
  logic [MAX_NWR-1:0][AW-1:0]    wr_addr;
  logic [MAX_NWR-1:0][XLEN-1:0]  wr_data;
  logic                          claim_act;

  logic [NREG-1:0][XLEN-1:0]     mem;
  logic [NREG-1:0][XLEN-1:0]     mem_nxt;
  logic [NREG-1:0][MAX_NWR-1:0]  st_match;
  winner_t [NREG-1:0]            st_win;
  logic [NRD-1:0][MAX_NWR-1:0]   rd_match;
  winner_t [NRD-1:0]             rd_win;

  // Writes to a hardwired x0 are dropped here, which also keeps x0 out of bypass.
  // Gating with rst_i makes every read return zero while reset is held.
  always_comb begin
    wr_act  = '0;
    wr_addr = '0;
    wr_data = '0;
    for (int p = 0; p < NWR; p++) begin
      wr_addr[p] = bus.wr_addr_i[p];
      wr_data[p] = bus.wr_data_i[p];
      wr_act[p]  = bus.wr_en_i[p] && !rst_i &&
                   !((ZERO_REG != 0) && (bus.wr_addr_i[p] == '0));
    end
    claim_act = bus.claim_en_i && !((ZERO_REG != 0) && (bus.claim_addr_i == '0));
  end

  always_comb begin
    mem_nxt  = mem;
    st_match = '0;
    st_win   = '0;
    for (int r = 0; r < NREG; r++) begin
      for (int p = 0; p < MAX_NWR; p++) begin
        st_match[r][p] = wr_act[p] && (wr_addr[p] == AW'(r));
      end
      st_win[r] = write_winner(st_match[r]);
      if (st_win[r].hit) mem_nxt[r] = wr_data[st_win[r].port];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) mem <= '0;
    else       mem <= mem_nxt;
  end

  always_comb begin
    rd_match      = '0;
    rd_win        = '0;
    bus.rd_data_o = '0;
    for (int k = 0; k < NRD; k++) begin
      for (int p = 0; p < MAX_NWR; p++) begin
        rd_match[k][p] = wr_act[p] && (wr_addr[p] == bus.rd_addr_i[k]);
      end
      rd_win[k]        = write_winner(rd_match[k]);
      bus.rd_data_o[k] = rd_win[k].hit ? wr_data[rd_win[k].port] : mem[bus.rd_addr_i[k]];
    end
  end

  regfile_scoreboard #(
    .NREG (NREG),
    .NRD  (NRD)
  ) u_sb (
    .clk        (clk_i),
    .rst        (rst_i),
    .wr_act     (wr_act),
    .wr_addr    (wr_addr),
    .claim_act  (claim_act),
    .claim_addr (bus.claim_addr_i),
    .flush      (bus.flush_i),
    .rd_addr    (bus.rd_addr_i),
    .rd_busy    (bus.rd_busy_o)
  );

endmodule
